// File: rtl/bullet_spawner.sv
// bullet_spawner: turns a fire press into one spawn command for the first free slot of the bullet table.
// Latency: edge -> spawn_valid in 2+k cycles (k = first free slot); a full table drops the press after SLOTS scan cycles.
// Backpressure: spawn_index/spawn_word held stable while spawn_valid & ~spawn_ready; then COOLDOWN idle cycles.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   fire                fire button level (already synchronous)
//   ship_hor, ship_ver  ship position, latched on the accepted press
//   bullet_table        SLOTS x 24-bit table image; bit 23 of each slot is its active flag
//   spawn_valid/ready   spawn command handshake
//   spawn_index/word    target slot and {1, hor, ver} bullet word
//   shots_fired         accepted spawns (wrapping)
//   shots_dropped       presses lost to a full table (wrapping)
module bullet_spawner #(
  parameter int SLOTS        = 32,
  parameter int INDEX_W      = 5,
  parameter int COOLDOWN     = 500000,
  parameter int SPAWN_OFFSET = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fire,
  input  logic [11:0]          ship_hor,
  input  logic [10:0]          ship_ver,
  input  logic [SLOTS*24-1:0]  bullet_table,
  output logic                 spawn_valid,
  input  logic                 spawn_ready,
  output logic [INDEX_W-1:0]   spawn_index,
  output logic [23:0]          spawn_word,
  output logic [15:0]          shots_fired,
  output logic [15:0]          shots_dropped
);

  localparam int                 CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(SLOTS - 1);
  localparam logic [10:0]        VER_OFF  = 11'(SPAWN_OFFSET);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OFFER, S_COOL} state_t;

  state_t             r_state;
  logic               r_fire_q;
  logic [11:0]        r_hor;
  logic [10:0]        r_ver;
  logic [INDEX_W-1:0] r_scan_idx;
  logic [CNT_W-1:0]   r_cool_cnt;
  logic               r_spawn_valid;
  logic [INDEX_W-1:0] r_spawn_index;
  logic [23:0]        r_spawn_word;
  logic [15:0]        r_shots_fired;
  logic [15:0]        r_shots_dropped;

  logic [SLOTS-1:0]   w_active;
  logic [10:0]        w_ver_clamped;
  logic               w_edge;
  logic               w_unused_tbl;

  // Gather the active flags so the scan is a plain bit-select by slot index.
  for (genvar s = 0; s < SLOTS; s++) begin : g_active
    assign w_active[s] = bullet_table[24*s+23];
  end

  // Only the active flags matter here; the position fields belong to the table.
  assign w_unused_tbl = ^bullet_table;

  assign w_edge        = fire & ~r_fire_q;
  // Spawn point sits above the ship; saturate at the top edge instead of wrapping.
  assign w_ver_clamped = (r_ver < VER_OFF) ? 11'd0 : (r_ver - VER_OFF);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_fire_q        <= 1'b1;  // a button held through reset must not count as a press
      r_hor           <= '0;
      r_ver           <= '0;
      r_scan_idx      <= '0;
      r_cool_cnt      <= '0;
      r_spawn_valid   <= 1'b0;
      r_spawn_index   <= '0;
      r_spawn_word    <= '0;
      r_shots_fired   <= '0;
      r_shots_dropped <= '0;
    end else begin
      r_fire_q <= fire;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_hor      <= ship_hor;
            r_ver      <= ship_ver;
            r_scan_idx <= '0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_active[r_scan_idx]) begin
            r_spawn_index <= r_scan_idx;
            r_spawn_word  <= {1'b1, r_hor, w_ver_clamped};
            r_spawn_valid <= 1'b1;
            r_state       <= S_OFFER;
          end else if (r_scan_idx == LAST_IDX) begin
            r_shots_dropped <= r_shots_dropped + 16'd1;
            r_state         <= S_IDLE;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        S_OFFER: begin
          // Slot occupancy is not rechecked; the table owns any conflict resolution.
          if (spawn_ready) begin
            r_spawn_valid <= 1'b0;
            r_shots_fired <= r_shots_fired + 16'd1;
            r_cool_cnt    <= CNT_LOAD;
            r_state       <= S_COOL;
          end
        end
        S_COOL: begin
          if (r_cool_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cool_cnt <= r_cool_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spawn_valid   = r_spawn_valid;
  assign spawn_index   = r_spawn_index;
  assign spawn_word    = r_spawn_word;
  assign shots_fired   = r_shots_fired;
  assign shots_dropped = r_shots_dropped;

endmodule

// File: tb/tb_bullet_spawner.sv
module tb_bullet_spawner;

  localparam int SLOTS    = 32;
  localparam int COOLDOWN = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                fire;
  logic [11:0]         ship_hor;
  logic [10:0]         ship_ver;
  logic [SLOTS*24-1:0] bullet_table;
  logic                spawn_valid;
  logic                spawn_ready;
  logic [4:0]          spawn_index;
  logic [23:0]         spawn_word;
  logic [15:0]         shots_fired;
  logic [15:0]         shots_dropped;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fired = 0;
  int exp_dropped = 0;

  bullet_spawner #(
    .SLOTS(SLOTS), .INDEX_W(5), .COOLDOWN(COOLDOWN), .SPAWN_OFFSET(16)
  ) dut (
    .clock(clock), .reset(reset), .fire(fire),
    .ship_hor(ship_hor), .ship_ver(ship_ver), .bullet_table(bullet_table),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_index(spawn_index), .spawn_word(spawn_word),
    .shots_fired(shots_fired), .shots_dropped(shots_dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] mask;       // active slots
    logic [11:0] hor;
    logic [10:0] ver;
    int          exp_lat;    // ticks from edge to spawn_valid; 0 = table full, press dropped
    logic [4:0]  exp_idx;
    logic [10:0] exp_ver;
    int          hold;       // cycles ready is held low while valid
    logic        rdy_early;  // ready already high before valid rises
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Active flag from the mask; other bits carry junk so only bit 23 may steer the scan.
  function automatic logic [SLOTS*24-1:0] mk_table(input logic [31:0] mask);
    logic [SLOTS*24-1:0] t;
    t = '0;
    for (int s = 0; s < SLOTS; s++) t[24*s +: 24] = {mask[s], 23'(s * 37 + 5)};
    return t;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    int drop_lat;
    logic [15:0] d0;
    logic [23:0] exp_word;
    exp_word     = {1'b1, v.hor, v.exp_ver};
    bullet_table = mk_table(v.mask);
    ship_hor     = v.hor;
    ship_ver     = v.ver;
    spawn_ready  = v.rdy_early;
    fire         = 1'b0;
    tick();
    d0 = shots_dropped;
    drop_lat = 0;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    lat = 1;
    while (!spawn_valid && lat < 40) begin
      tick();
      lat++;
      if (drop_lat == 0 && shots_dropped != d0) drop_lat = lat;
    end
    if (v.exp_lat == 0) begin
      exp_dropped++;
      chk("full_no_valid", 32'(spawn_valid), 32'd0);
      chk("full_drop_lat", drop_lat, 33);
      chk("full_dropped", 32'(shots_dropped), exp_dropped);
    end else begin
      chk("vec_latency", lat, v.exp_lat);
      chk("vec_index", 32'(spawn_index), 32'(v.exp_idx));
      chk("vec_word", 32'(spawn_word), 32'(exp_word));
      for (int h = 0; h < v.hold; h++) begin
        ship_hor = ~v.hor;
        ship_ver = v.ver + 11'd1;
        tick();
        chk("hold_valid", 32'(spawn_valid), 32'd1);
        chk("hold_index", 32'(spawn_index), 32'(v.exp_idx));
        chk("hold_word", 32'(spawn_word), 32'(exp_word));
      end
      spawn_ready = 1'b1;
      tick();
      exp_fired++;
      chk("hs_valid_low", 32'(spawn_valid), 32'd0);
      chk("hs_fired", 32'(shots_fired), exp_fired);
      spawn_ready = 1'b0;
      repeat (COOLDOWN + 1) tick();
    end
  endtask

  initial begin
    logic seen;
    //          mask          hor        ver        lat idx    exp_ver     hold early
    vecs[0] = '{32'h0000_0000, 12'd100,  11'd200,  2,  5'd0,  11'd184,  0, 1'b1};
    vecs[1] = '{32'h0000_007F, 12'd300,  11'd50,   9,  5'd7,  11'd34,   5, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 12'd1,    11'd100,  0,  5'd0,  11'd0,    0, 1'b0};
    vecs[3] = '{32'h0000_0000, 12'd7,    11'd5,    2,  5'd0,  11'd0,    0, 1'b1};
    vecs[4] = '{32'h0000_0000, 12'd4095, 11'd16,   2,  5'd0,  11'd0,    0, 1'b0};
    vecs[5] = '{32'h0000_0000, 12'd0,    11'd17,   2,  5'd0,  11'd1,    0, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 12'd2047, 11'd2047, 33, 5'd31, 11'd2031, 2, 1'b0};
    vecs[7] = '{32'hFFFF_EFFF, 12'd1234, 11'd1000, 14, 5'd12, 11'd984,  1, 1'b0};

    // Reset with the button held, then release reset while still holding it.
    reset = 1'b1; fire = 1'b1; spawn_ready = 1'b0;
    ship_hor = 12'd10; ship_ver = 11'd40; bullet_table = mk_table(32'h0);
    repeat (3) tick();
    chk("rst_valid", 32'(spawn_valid), 32'd0);
    chk("rst_index", 32'(spawn_index), 32'd0);
    chk("rst_word", 32'(spawn_word), 32'd0);
    chk("rst_fired", 32'(shots_fired), 32'd0);
    chk("rst_dropped", 32'(shots_dropped), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); if (spawn_valid) seen = 1'b1; end
    chk("held_through_reset", 32'(seen), 32'd0);
    fire = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Presses during OFFER and during COOL, button held across COOL.
    bullet_table = mk_table(32'h0); ship_hor = 12'd500; ship_ver = 11'd300;
    spawn_ready = 1'b0; fire = 1'b0; tick();
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("b_valid", 32'(spawn_valid), 32'd1);
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("b_offer_press_valid", 32'(spawn_valid), 32'd1);
    chk("b_offer_press_word", 32'(spawn_word), 32'({1'b1, 12'd500, 11'd284}));
    fire = 1'b1; spawn_ready = 1'b1; tick(); exp_fired++;
    chk("b_hs_valid_low", 32'(spawn_valid), 32'd0);
    spawn_ready = 1'b0;
    seen = 1'b0;
    repeat (10) begin tick(); if (spawn_valid) seen = 1'b1; end
    chk("b_held_no_spawn", 32'(seen), 32'd0);
    chk("b_fired_once", 32'(shots_fired), exp_fired);
    fire = 1'b0; tick();
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("b_second_valid", 32'(spawn_valid), 32'd1);
    spawn_ready = 1'b1; tick(); exp_fired++; spawn_ready = 1'b0;
    chk("b_fired_twice", 32'(shots_fired), exp_fired);
    // Edge in the very first IDLE cycle after COOL is accepted.
    repeat (COOLDOWN) tick();
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("b_first_idle_valid", 32'(spawn_valid), 32'd1);
    spawn_ready = 1'b1; tick(); exp_fired++; spawn_ready = 1'b0;
    chk("b_fired_third", 32'(shots_fired), exp_fired);
    // Edge in the last COOL cycle is discarded.
    repeat (COOLDOWN - 1) tick();
    fire = 1'b1; tick(); fire = 1'b0;
    seen = 1'b0;
    repeat (10) begin tick(); if (spawn_valid) seen = 1'b1; end
    chk("b_last_cool_discard", 32'(seen), 32'd0);
    chk("b_fired_unchanged", 32'(shots_fired), exp_fired);

    // Reset during OFFER with ready low abandons the command.
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("c_valid_before_rst", 32'(spawn_valid), 32'd1);
    reset = 1'b1; tick();
    exp_fired = 0; exp_dropped = 0;
    chk("c_rst_valid", 32'(spawn_valid), 32'd0);
    chk("c_rst_fired", 32'(shots_fired), exp_fired);
    chk("c_rst_dropped", 32'(shots_dropped), exp_dropped);
    chk("c_rst_word", 32'(spawn_word), 32'd0);
    reset = 1'b0; tick();
    fire = 1'b1; tick(); fire = 1'b0; tick();
    chk("c_after_rst_valid", 32'(spawn_valid), 32'd1);
    chk("c_after_rst_index", 32'(spawn_index), 32'd0);
    spawn_ready = 1'b1; tick(); exp_fired++; spawn_ready = 1'b0;
    chk("c_after_rst_fired", 32'(shots_fired), exp_fired);
    repeat (COOLDOWN + 1) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bullet_spawner.md
# bullet_spawner

Upstream stage of the bullet table. Converts a player fire press into a single spawn command for the first free slot in the 32-entry bullet table. It scans the table's active bits one slot per cycle, offers a fully formed 24-bit bullet word over a valid/ready handshake, then enforces a fire cooldown. The bullet table consumes the command by writing the word into the indexed slot.

## Interface
Parameters:
- SLOTS, 32, number of bullet slots in the table
- INDEX_W, 5, slot index width (log2 SLOTS)
- COOLDOWN, 500000, idle cycles enforced after each accepted spawn (≥1)
- SPAWN_OFFSET, 16, pixels subtracted from ship vertical position for the spawn point

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fire  in  1  fire button level, already synchronous to clock
- ship_hor  in  12  ship horizontal position
- ship_ver  in  11  ship vertical position
- bullet_table  in  SLOTS*24  current table. Slot s occupies bits [24s+23:24s]: bit 23 active, bits 22:11 horizontal, bits 10:0 vertical.
- spawn_valid  out  1  spawn command offered
- spawn_ready  in  1  table accepts command this cycle
- spawn_index  out  INDEX_W  target slot
- spawn_word  out  24  {1'b1, hor[11:0], ver[10:0]}
- shots_fired  out  16  accepted spawns, wraps at 65535→0
- shots_dropped  out  16  fire presses lost to a full table, wraps

## Operation
- Edge detect: fire_q <= fire every cycle in every state. An edge is fire & ~fire_q. fire_q resets to 1, so a button held through reset never fires.
- FSM states: IDLE, SCAN, OFFER, COOL.
- IDLE: on an edge, latch ship_hor and ship_ver, set scan_idx=0, go to SCAN. Otherwise stay.
- SCAN: test bullet_table[24*scan_idx+23] live each cycle.
  - If 0: latch spawn_index=scan_idx, go to OFFER.
  - If 1 and scan_idx==SLOTS-1: shots_dropped++, go to IDLE.
  - If 1 otherwise: scan_idx++.
- OFFER: spawn_valid=1. spawn_index and spawn_word are held stable until spawn_valid & spawn_ready. On the handshake: shots_fired++, load cooldown counter with COOLDOWN-1, go to COOL. The block does not recheck slot occupancy during OFFER.
- COOL: decrement the counter. When it is 0, go to IDLE.
- Edges occurring in SCAN, OFFER or COOL are discarded, not queued.
- Spawn vertical position: ver_latched - SPAWN_OFFSET, clamped to 0 if ver_latched < SPAWN_OFFSET. No wrap-around.
- Horizontal position is passed through unchanged.
- spawn_word[23] is always 1.
- Reset values: state IDLE, spawn_valid 0, spawn_index 0, spawn_word 0, shots_fired 0, shots_dropped 0, scan_idx 0, cooldown counter 0, fire_q 1.
- Reset mid-operation, including OFFER with ready low: all state returns to reset values at the next edge. spawn_valid is low in the cycle after reset is sampled, and the pending command is abandoned.

## Timing
- Edge seen in IDLE at cycle N → SCAN from N+1. Free slot k is found in cycle N+1+k. spawn_valid is high from cycle N+2+k.
- Best case (slot 0 free): 2 cycles from the fire edge to spawn_valid.
- Full table: SLOTS cycles in SCAN. shots_dropped is updated and the FSM is in IDLE at cycle N+1+SLOTS. spawn_valid is never asserted.
- Handshake sampled at edge M → spawn_valid low at M+1. COOL occupies COOLDOWN cycles. IDLE begins at M+1+COOLDOWN, and an edge can be accepted in that cycle.
- If spawn_ready is already high when spawn_valid rises, OFFER lasts exactly 1 cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Empty table, COOLDOWN=4, ship (100,200), one fire pulse → spawn_valid 2 cycles after the edge, index 0, word {1,100,184}. With ready tied high: 1-cycle valid, shots_fired=1.
- Slots 0–6 active, fire → valid at edge+9, index 7. Hold ready low 5 cycles, changing ship_hor meanwhile → index and word stay constant until ready.
- All 32 slots active, fire → no spawn_valid, shots_dropped=1 at edge+33, FSM back in IDLE.
- Fire pressed again during OFFER and during COOL, and button held across COOL → exactly one spawn. A new press right after IDLE resumes → second spawn, shots_fired=2.
- ship_ver=5 with SPAWN_OFFSET=16 → spawn vertical field 0 (clamped). ship_ver=16 → 0. ship_ver=17 → 1.
- Fire held through reset release → no spawn. Reset asserted during OFFER with ready low → spawn_valid 0 the next cycle, both counters 0, next press spawns normally.
